fulladd_resp_checker: RTL and testbench

- Response-side checker for the full-adder test path: sits opposite the stimulus driver and watches the full adder's outputs.
- Captures each applied vector (x, y, cin), waits a programmable settle time, then samples the adder outputs (s, cout) and compares them against a golden sum/carry.
- Keeps pass/fail statistics and latches the first failing vector.
- Synthesizable, so the same checker serves simulation and on-board self-test of FullAdderStructure.

---
 rtl/fulladd_resp_checker_if.sv | 31 +++
 rtl/fulladd_resp_checker.sv | 119 +++++++++++
 tb/tb_fulladd_resp_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fulladd_resp_checker_if.sv
// Signal bundle between the full-adder stimulus/response path and the response checker.
// The master side applies vectors and drives the adder outputs; the checker is the slave.
interface fulladd_resp_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             vec_valid;
  logic             x;
  logic             y;
  logic             cin;
  logic             s;
  logic             cout;
  logic             busy;
  logic             chk_valid;
  logic             chk_ok;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [4:0]       first_err_vec;
  logic             overrun;
  logic             done;
  logic             pass;

  modport master (
    output vec_valid, x, y, cin, s, cout,
    input  busy, chk_valid, chk_ok, vec_cnt, err_cnt, first_err_vec, overrun, done, pass
  );

  modport slave (
    input  vec_valid, x, y, cin, s, cout,
    output busy, chk_valid, chk_ok, vec_cnt, err_cnt, first_err_vec, overrun, done, pass
  );
endinterface

// File: rtl/fulladd_resp_checker.sv
// Full-adder response checker: latches each applied vector, waits SETTLE cycles,
// compares s/cout against the golden sum/carry and keeps pass/fail statistics.
module fulladd_resp_checker #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned NUM_VEC = 11,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fulladd_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [7:0]       WAIT_LOAD = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] VEC_LIMIT = CNT_W'(NUM_VEC);

  state_t           state;
  logic [2:0]       vec;
  logic [7:0]       wait_cnt;
  logic             busy;
  logic             chk_valid;
  logic             chk_ok;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [4:0]       first_err_vec;
  logic             overrun;
  logic             done;
  logic             pass;

  logic             resp_ok;
  logic [CNT_W-1:0] vec_cnt_nxt;

  // Golden {sum, carry} for a latched {x, y, cin}.
  function automatic logic [1:0] golden(input logic [2:0] v);
    golden = {v[2] ^ v[1] ^ v[0], (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
  endfunction

  // Case-equality so an X/Z response never counts as a match in simulation.
  function automatic logic resp_match(input logic [1:0] got, input logic [1:0] exp);
    resp_match = (got === exp);
  endfunction

  assign resp_ok     = resp_match({bus.s, bus.cout}, golden(vec));
  assign vec_cnt_nxt = vec_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      vec           <= '0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      chk_valid     <= 1'b0;
      chk_ok        <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_vec <= '0;
      overrun       <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      chk_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.vec_valid) begin
            vec      <= {bus.x, bus.y, bus.cin};
            wait_cnt <= WAIT_LOAD;
            busy     <= 1'b1;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (bus.vec_valid) overrun <= 1'b1;
          if (wait_cnt == '0) state <= S_CHECK;
          else                wait_cnt <= wait_cnt - 8'd1;
        end
        S_CHECK: begin
          // A strobe here is still an overrun even though the state leaves CHECK now.
          if (bus.vec_valid) overrun <= 1'b1;
          chk_valid <= 1'b1;
          chk_ok    <= resp_ok;
          vec_cnt   <= vec_cnt_nxt;
          busy      <= 1'b0;
          if (!resp_ok) begin
            err_cnt <= err_cnt + CNT_W'(1);
            if (err_cnt == '0) first_err_vec <= {vec, bus.s, bus.cout};
          end
          if (vec_cnt_nxt == VEC_LIMIT) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= resp_ok && (err_cnt == '0);
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy;
  assign bus.chk_valid     = chk_valid;
  assign bus.chk_ok        = chk_ok;
  assign bus.vec_cnt       = vec_cnt;
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err_vec = first_err_vec;
  assign bus.overrun       = overrun;
  assign bus.done          = done;
  assign bus.pass          = pass;

endmodule

// File: tb/tb_fulladd_resp_checker.sv
// Bench for fulladd_resp_checker: a behavioural full adder with injectable faults
// drives the response, and an arithmetic reference model predicts every result.
module tb_fulladd_resp_checker;

  localparam int SETTLE  = 2;
  localparam int NUM_VEC = 11;
  localparam int CNT_W   = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  fulladd_resp_checker_if #(.CNT_W(CNT_W)) bus_if ();

  fulladd_resp_checker #(
    .SETTLE (SETTLE),
    .NUM_VEC(NUM_VEC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // Adder under test: its inputs are kept apart from the strobe bus so a rejected
  // strobe can present a different vector without disturbing the in-flight one.
  logic ax, ay, acin;
  logic stuck_c0, flip_s;
  logic ad_s, ad_c;

  always_comb begin
    {ad_c, ad_s} = 2'(ax) + 2'(ay) + 2'(acin);
    if (stuck_c0) ad_c = 1'b0;
    if (flip_s)   ad_s = ~ad_s;
  end

  assign bus_if.s    = ad_s;
  assign bus_if.cout = ad_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  int         m_last;
  int         m_vec;
  int         m_err;
  logic [4:0] m_first;
  bit         m_ovr;
  bit         m_done;
  bit         exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.chk_valid) begin
      if (exp_q.size() == 0) check("unexpected_chk_valid", 32'(1), 32'(0));
      else                   check("chk_ok", 32'(bus_if.chk_ok), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n            = 1'b0;
    bus_if.vec_valid = 1'b0;
    repeat (n) tick();
    rst_n   = 1'b1;
    m_last  = -1000;
    m_vec   = 0;
    m_err   = 0;
    m_first = '0;
    m_ovr   = 1'b0;
    m_done  = 1'b0;
    exp_q.delete();
  endtask

  // Strobe vector v for one cycle, then idle so the next strobe is gap cycles later.
  task automatic send(input logic [2:0] v, input bit stuck, input bit flip, input int gap);
    int         e;
    bit         acc;
    logic [1:0] sum;
    logic [1:0] got;
    e   = cyc + 1;
    acc = !m_done && (e - m_last >= SETTLE + 2);
    if (!m_done && !acc) m_ovr = 1'b1;
    {bus_if.x, bus_if.y, bus_if.cin} = v;
    if (acc) begin
      {ax, ay, acin} = v;
      stuck_c0 = stuck;
      flip_s   = flip;
      sum = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      got = sum;
      if (stuck) got[1] = 1'b0;
      if (flip)  got[0] = ~got[0];
      m_last = e;
      m_vec++;
      exp_q.push_back(got == sum);
      if (got != sum) begin
        if (m_err == 0) m_first = {v, got[0], got[1]};
        m_err++;
      end
      if (m_vec == NUM_VEC) m_done = 1'b1;
    end
    bus_if.vec_valid = 1'b1;
    tick();
    bus_if.vec_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic check_final(input string tag);
    repeat (SETTLE + 3) tick();
    check({tag, ".vec_cnt"},       32'(bus_if.vec_cnt),       32'(m_vec));
    check({tag, ".err_cnt"},       32'(bus_if.err_cnt),       32'(m_err));
    check({tag, ".first_err_vec"}, 32'(bus_if.first_err_vec), 32'(m_first));
    check({tag, ".overrun"},       32'(bus_if.overrun),       32'(m_ovr));
    check({tag, ".done"},          32'(bus_if.done),          32'(m_done));
    check({tag, ".pass"},          32'(bus_if.pass),          32'(m_done && m_err == 0));
    check({tag, ".busy"},          32'(bus_if.busy),          32'(0));
    check({tag, ".pending"},       32'(exp_q.size()),         32'(0));
  endtask

  logic [2:0] plan [NUM_VEC] = '{3'b000, 3'b100, 3'b010, 3'b100, 3'b000, 3'b110,
                                 3'b101, 3'b011, 3'b101, 3'b001, 3'b111};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    {bus_if.x, bus_if.y, bus_if.cin} = 3'b000;
    {ax, ay, acin} = 3'b000;
    stuck_c0 = 1'b0;
    flip_s   = 1'b0;

    do_reset(2);
    check("rst.busy",          32'(bus_if.busy),          32'(0));
    check("rst.chk_valid",     32'(bus_if.chk_valid),     32'(0));
    check("rst.chk_ok",        32'(bus_if.chk_ok),        32'(0));
    check("rst.vec_cnt",       32'(bus_if.vec_cnt),       32'(0));
    check("rst.err_cnt",       32'(bus_if.err_cnt),       32'(0));
    check("rst.first_err_vec", 32'(bus_if.first_err_vec), 32'(0));
    check("rst.overrun",       32'(bus_if.overrun),       32'(0));
    check("rst.done",          32'(bus_if.done),          32'(0));
    check("rst.pass",          32'(bus_if.pass),          32'(0));

    for (int i = 0; i < NUM_VEC; i++) send(plan[i], 1'b0, 1'b0, 40);
    check_final("allpass");

    for (int i = 0; i < 3; i++) send(3'b111, 1'b0, 1'b0, 5);
    check_final("postdone");

    do_reset(2);
    repeat (5) tick();
    send(3'b110, 1'b0, 1'b0, 1);
    for (int i = 1; i <= SETTLE + 3; i++) begin
      check($sformatf("lat.busy[%0d]", i),      32'(bus_if.busy),      32'(i <= SETTLE + 1));
      check($sformatf("lat.chk_valid[%0d]", i), 32'(bus_if.chk_valid), 32'(i == SETTLE + 2));
      tick();
    end
    check_final("latency");

    do_reset(2);
    for (int i = 0; i < NUM_VEC; i++) send(plan[i], 1'b1, 1'b0, SETTLE + 2);
    check_final("stuck_cout");

    do_reset(2);
    send(3'b110, 1'b0, 1'b0, 2);
    send(3'b001, 1'b0, 1'b0, 40);
    check_final("overrun");

    do_reset(2);
    send(3'b011, 1'b0, 1'b0, SETTLE + 1);
    send(3'b100, 1'b0, 1'b0, 40);
    check_final("overrun_at_check");

    do_reset(2);
    send(3'b111, 1'b0, 1'b0, 1);
    do_reset(1);
    repeat (10) tick();
    check_final("rst_mid_settle");
    send(3'b101, 1'b0, 1'b1, 20);
    check_final("after_rst");

    for (int r = 0; r < 4; r++) begin
      do_reset(2);
      for (int k = 0; k < 16; k++) begin
        send(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, int'($urandom_range(1, SETTLE + 6)));
      end
      check_final($sformatf("random%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
